// File: rtl/img_pkg.sv
// Shared constants for the UART image sequencer: FSM state codes, pixel-op
// mode codes and the frame header length.
package img_pkg;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_HDR_W  = 4'd1;
  localparam logic [3:0] S_HDR_H  = 4'd2;
  localparam logic [3:0] S_CHECK  = 4'd3;
  localparam logic [3:0] S_RX_PIX = 4'd4;
  localparam logic [3:0] S_TX_HW  = 4'd5;
  localparam logic [3:0] S_TX_HH  = 4'd6;
  localparam logic [3:0] S_TX_RD  = 4'd7;
  localparam logic [3:0] S_TX_PIX = 4'd8;
  localparam logic [3:0] S_ERR    = 4'd9;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_THR  = 2'd2;
  localparam logic [1:0] MODE_INC  = 2'd3;

  // Header bytes on the wire ahead of the pixels: width then height.
  localparam int HDR_LEN = 2;

endpackage

// File: rtl/img_uart_seq_if.sv
// Bundle of control, UART FIFO and pixel-memory signals around the sequencer.
// master = the sequencer, slave = the surrounding system.
interface img_uart_seq_if #(parameter int ADDR_W = 12);
  logic              start;
  logic [1:0]        mode;
  logic              rx_empty;
  logic [7:0]        r_data;
  logic              rd_uart;
  logic              tx_full;
  logic [7:0]        w_data;
  logic              wr_uart;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, mode, rx_empty, r_data, tx_full, mem_rdata,
    output rd_uart, w_data, wr_uart, mem_we, mem_addr, mem_wdata, busy, done, err
  );

  modport slave (
    output start, mode, rx_empty, r_data, tx_full, mem_rdata,
    input  rd_uart, w_data, wr_uart, mem_we, mem_addr, mem_wdata, busy, done, err
  );
endinterface

// File: rtl/img_uart_seq_pix_op.sv
// Combinational per-pixel operation applied on the transmit path.
module pix_op
  import img_pkg::*;
(
  input  logic [7:0] pix,
  input  logic [1:0] mode,
  output logic [7:0] res
);

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    res = pix;
    case (mode)
      MODE_PASS: res = pix;
      MODE_INV:  res = ~pix;
      MODE_THR:  res = pix[7] ? 8'hFF : 8'h00;
      MODE_INC:  res = (pix == 8'hFF) ? 8'hFF : pix + 8'd1;
      default:   res = pix;
    endcase
  end

endmodule

// File: rtl/img_uart_seq.sv
// Frame sequencer: receives W, H and W*H pixels over UART into pixel memory,
// then echoes the header and streams every pixel back through pix_op.
module img_uart_seq
  import img_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int MAX_PIX = 4096,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic           clk,
  input  logic           reset,
  img_uart_seq_if.master bus
);

  logic [3:0]  state;
  logic [1:0]  mode_q;
  logic [7:0]  hdr_q [HDR_LEN];
  logic [15:0] n_q;
  logic [15:0] cnt;
  logic [31:0] idle_cnt;
  logic [7:0]  pix_q;
  logic        pix_held;
  logic        err_q;

  logic        rx_state, pop, push, last, timeout_hit;
  logic [15:0] n_calc;
  logic [7:0]  cur_pix, op_pix;

  assign rx_state    = (state == S_HDR_W) || (state == S_HDR_H) || (state == S_RX_PIX);
  assign pop         = rx_state && !bus.rx_empty;
  assign push        = ((state == S_TX_HW) || (state == S_TX_HH) || (state == S_TX_PIX)) && !bus.tx_full;
  assign last        = (cnt == n_q - 16'd1);
  assign timeout_hit = rx_state && bus.rx_empty && (idle_cnt == 32'(TIMEOUT - 1));
  assign n_calc      = {8'd0, hdr_q[0]} * {8'd0, hdr_q[1]};

  // The read result is only guaranteed on the first TX_PIX cycle; a stall holds it in pix_q.
  assign cur_pix = pix_held ? pix_q : bus.mem_rdata;

  pix_op u_pix_op (
    .pix  (cur_pix),
    .mode (mode_q),
    .res  (op_pix)
  );

  assign bus.rd_uart   = pop;
  assign bus.mem_we    = (state == S_RX_PIX) && !bus.rx_empty;
  assign bus.mem_wdata = bus.mem_we ? bus.r_data : 8'h00;
  assign bus.mem_addr  = ((state == S_RX_PIX) || (state == S_TX_RD) || (state == S_TX_PIX))
                         ? cnt[ADDR_W-1:0] : '0;
  assign bus.wr_uart   = push;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_TX_PIX) && push && last;
  assign bus.err       = err_q;

  always_comb begin
    bus.w_data = 8'h00;
    case (state)
      S_TX_HW:  bus.w_data = hdr_q[0];
      S_TX_HH:  bus.w_data = hdr_q[1];
      S_TX_PIX: bus.w_data = op_pix;
      default:  bus.w_data = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      mode_q   <= MODE_PASS;
      for (int i = 0; i < HDR_LEN; i++) hdr_q[i] <= 8'h00;
      n_q      <= 16'd0;
      cnt      <= 16'd0;
      idle_cnt <= 32'd0;
      pix_q    <= 8'h00;
      pix_held <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      idle_cnt <= (!rx_state || pop) ? 32'd0 : idle_cnt + 32'd1;

      case (state)
        S_IDLE: if (bus.start) begin
          err_q  <= 1'b0;
          mode_q <= bus.mode;
          state  <= S_HDR_W;
        end
        S_HDR_W, S_HDR_H: begin
          if (timeout_hit) begin
            err_q <= 1'b1;
            state <= S_ERR;
          end else if (pop) begin
            hdr_q[(state == S_HDR_W) ? 0 : 1] <= bus.r_data;
            state <= (state == S_HDR_W) ? S_HDR_H : S_CHECK;
          end
        end
        S_CHECK: begin
          n_q <= n_calc;
          cnt <= 16'd0;
          if (n_calc == 16'd0 || 32'(n_calc) > 32'(MAX_PIX)) begin
            err_q <= 1'b1;
            state <= S_ERR;
          end else begin
            state <= S_RX_PIX;
          end
        end
        S_RX_PIX: begin
          if (timeout_hit) begin
            err_q <= 1'b1;
            state <= S_ERR;
          end else if (pop) begin
            if (last) state <= S_TX_HW;
            else      cnt   <= cnt + 16'd1;
          end
        end
        S_TX_HW: if (push) state <= S_TX_HH;
        S_TX_HH: if (push) begin
          cnt   <= 16'd0;
          state <= S_TX_RD;
        end
        S_TX_RD: begin
          pix_held <= 1'b0;
          state    <= S_TX_PIX;
        end
        S_TX_PIX: begin
          if (!pix_held) begin
            pix_q    <= bus.mem_rdata;
            pix_held <= 1'b1;
          end
          if (push) begin
            if (last) begin
              cnt   <= 16'd0;
              state <= S_IDLE;
            end else begin
              cnt   <= cnt + 16'd1;
              state <= S_TX_RD;
            end
          end
        end
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_uart_seq.sv
// Self-checking bench for img_uart_seq: FIFO/memory models around the DUT and
// a frame-level reference model of the expected transmit stream.
module tb_img_uart_seq;
  import img_pkg::*;

  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  img_uart_seq_if #(.ADDR_W(ADDR_W)) bus ();

  img_uart_seq #(.ADDR_W(ADDR_W), .MAX_PIX(4096), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_got[$];
  logic [7:0] mem [0:4095];
  bit rx_rand = 0, tx_rand = 0, tx_force = 0;
  int rd_viol = 0, wr_viol = 0, mem_we_cnt = 0, wr_cnt = 0, done_cnt = 0, idle_run = 0;

  // Frame under test and snapshots taken at its start.
  logic [7:0] fw, fh;
  logic [7:0] fpx[$];
  int d0, t0, w0, wr0;

  // UART FIFO and memory models; DUT outputs are sampled on the rising edge.
  always @(posedge clk) begin
    if (bus.rd_uart) begin
      if (bus.rx_empty) rd_viol++;
      else void'(rx_q.pop_front());
      idle_run = 0;
    end else if (bus.busy && bus.rx_empty) begin
      idle_run++;
    end
    if (bus.wr_uart) begin
      if (bus.tx_full) wr_viol++;
      tx_got.push_back(bus.w_data);
      wr_cnt++;
    end
    if (bus.mem_we) mem_we_cnt++;
    if (bus.done) done_cnt++;
  end

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  always @(negedge clk) begin
    bus.rx_empty = (rx_q.size() == 0) || (rx_rand && $urandom_range(0, 2) == 0);
    bus.r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    bus.tx_full  = tx_force || (tx_rand && $urandom_range(0, 2) == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] op_ref(input logic [1:0] m, input logic [7:0] p);
    int v;
    case (m)
      2'd0:    v = p;
      2'd1:    v = 255 - p;
      2'd2:    v = (p >= 128) ? 255 : 0;
      default: v = (p + 1 > 255) ? 255 : p + 1;
    endcase
    return v[7:0];
  endfunction

  task automatic set_frame(input logic [7:0] w, input logic [7:0] h, input bit rnd);
    logic [7:0] lit [4];
    lit = '{8'h10, 8'h80, 8'hFF, 8'h00};
    fw = w;
    fh = h;
    fpx.delete();
    for (int i = 0; i < w * h; i++) fpx.push_back(rnd ? 8'($urandom) : lit[i % 4]);
  endtask

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    bus.mode  = m;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic begin_frame(input logic [1:0] m, input int n_px);
    d0 = done_cnt; t0 = tx_got.size(); w0 = mem_we_cnt; wr0 = wr_cnt;
    rx_q.push_back(fw);
    rx_q.push_back(fh);
    for (int i = 0; i < n_px; i++) rx_q.push_back(fpx[i]);
    pulse_start(m);
  endtask

  task automatic finish_frame(input string tag, input logic [1:0] m, input int bound);
    int cyc = 0, n = fpx.size(), bad = 0;
    logic [7:0] got;
    while (done_cnt == d0 && bus.err !== 1'b1 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_finished"}, 32'(cyc < bound), 1);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_mem_we"}, mem_we_cnt - w0, n);
    check({tag, "_tx_len"}, tx_got.size() - t0, n + HDR_LEN);
    check({tag, "_hdr_w"}, (tx_got.size() > t0) ? tx_got[t0] : 8'hxx, fw);
    check({tag, "_hdr_h"}, (tx_got.size() > t0 + 1) ? tx_got[t0 + 1] : 8'hxx, fh);
    for (int i = 0; i < n; i++) begin
      got = (tx_got.size() > t0 + HDR_LEN + i) ? tx_got[t0 + HDR_LEN + i] : 8'hxx;
      if (n <= 16) check($sformatf("%s_px%0d", tag, i), got, op_ref(m, fpx[i]));
      else if (got !== op_ref(m, fpx[i])) bad++;
    end
    if (n > 16) check({tag, "_px_bad"}, bad, 0);
  endtask

  task automatic wait_err(input string tag, input int bound);
    int cyc = 0;
    while (bus.err !== 1'b1 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_err_set"}, bus.err, 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    #2;
    // Reset state.
    check("rst_busy", bus.busy, 0);
    check("rst_outs", {bus.rd_uart, bus.wr_uart, bus.mem_we, bus.done, bus.err}, 0);
    check("rst_addr_data", {bus.mem_addr, bus.w_data}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Fixed four-pixel frame under every pixel op.
    for (int m = 0; m < 4; m++) begin
      set_frame(8'd2, 8'd2, 1'b0);
      begin_frame(2'(m), 4);
      finish_frame($sformatf("fixed_m%0d", m), 2'(m), 200);
    end

    // Zero-area and oversize frames are rejected without strobes.
    set_frame(8'd0, 8'd3, 1'b0);
    begin_frame(2'd0, 0);
    wait_err("w0", 100);
    @(negedge clk);
    check("w0_busy", bus.busy, 0);
    check("w0_strobes", (mem_we_cnt - w0) + (wr_cnt - wr0), 0);
    repeat (3) @(negedge clk);
    check("w0_sticky", bus.err, 1);

    fw = 8'd65; fh = 8'd64; fpx.delete();
    begin_frame(2'd1, 0);
    wait_err("big", 100);
    @(negedge clk);
    check("big_busy", bus.busy, 0);
    check("big_strobes", (mem_we_cnt - w0) + (wr_cnt - wr0), 0);

    // Largest accepted frame, 64x64.
    set_frame(8'd64, 8'd64, 1'b1);
    begin_frame(2'd3, 4096);
    finish_frame("max", 2'd3, 40000);

    // Transmit stall mid-frame.
    set_frame(8'd4, 8'd2, 1'b1);
    begin_frame(2'd0, 8);
    for (int c = 0; c < 500 && tx_got.size() - t0 < 4; c++) @(negedge clk);
    tx_force = 1'b1;
    @(negedge clk);
    wr0 = wr_cnt;
    repeat (20) @(negedge clk);
    check("stall_no_wr", wr_cnt - wr0, 0);
    tx_force = 1'b0;
    finish_frame("stall", 2'd0, 500);

    // Receive timeout: one pixel never arrives.
    set_frame(8'd2, 8'd2, 1'b1);
    begin_frame(2'd2, 3);
    wait_err("tmo", 400);
    check("tmo_idle_cycles", idle_run, TIMEOUT);
    check("tmo_mem_we", mem_we_cnt - w0, 3);
    check("tmo_wr", wr_cnt - wr0, 0);
    set_frame(8'd3, 8'd1, 1'b1);
    begin_frame(2'd1, 3);
    check("tmo_err_cleared", bus.err, 0);
    finish_frame("after_tmo", 2'd1, 300);

    // Reset in the middle of pixel reception.
    set_frame(8'd4, 8'd4, 1'b1);
    begin_frame(2'd0, 6);
    for (int c = 0; c < 200 && mem_we_cnt - w0 < 3; c++) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_strobes", {bus.rd_uart, bus.wr_uart, bus.mem_we, bus.done, bus.err}, 0);
    check("midrst_addr_data", {bus.mem_addr, bus.w_data, bus.mem_wdata}, 0);
    repeat (2) @(negedge clk);
    rx_q.delete();
    reset = 1'b1;
    set_frame(8'd2, 8'd3, 1'b1);
    begin_frame(2'd3, 6);
    finish_frame("after_rst", 2'd3, 300);

    // Randomized frames with FIFO back-pressure on both sides.
    rx_rand = 1'b1;
    tx_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      if (k == 2) begin
        set_frame(8'd3, 8'd2, 1'b1);
        begin_frame(m, 6);
        repeat (4) @(negedge clk);
        bus.mode  = ~m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end else begin
        set_frame(8'($urandom_range(1, 6)), 8'($urandom_range(1, 6)), 1'b1);
        begin_frame(m, fpx.size());
      end
      finish_frame($sformatf("rnd%0d", k), m, 2000);
    end
    rx_rand = 1'b0;
    tx_rand = 1'b0;

    check("rd_protocol", rd_viol, 0);
    check("wr_protocol", wr_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/img_uart_seq.md
IMG_UART_SEQ -- requirements
Module: img_uart_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, pixel-memory address width.
REQ-002 SHALL have parameter MAX_PIX, default 4096, largest accepted W*H.
REQ-003 SHALL have parameter TIMEOUT, default 50_000_000, receive idle limit in clk cycles.
REQ-004 SHALL have ports as follows; one clock, and reset is asynchronous and active-low:
  clk        in   1       system clock
  reset      in   1       asynchronous, active-low reset
  start      in   1       one-cycle pulse, begin a frame transaction
  mode       in   2       pixel op: 0 pass, 1 invert, 2 threshold, 3 saturating +1
  rx_empty   in   1       UART receive FIFO empty
  r_data     in   8       UART receive FIFO head byte
  rd_uart    out  1       pop receive FIFO, one-cycle pulse
  tx_full    in   1       UART transmit FIFO full
  w_data     out  8       byte to transmit
  wr_uart    out  1       push transmit FIFO, one-cycle pulse
  mem_we     out  1       pixel memory write enable
  mem_addr   out  ADDR_W  pixel memory address
  mem_wdata  out  8       pixel memory write data
  mem_rdata  in   8       pixel memory read data, valid 1 cycle after mem_addr
  busy       out  1       high in every state except IDLE
  done       out  1       one-cycle pulse on successful completion
  err        out  1       sticky error flag, cleared by next accepted start

Function
REQ-005 SHALL implement states IDLE, HDR_W, HDR_H, CHECK, RX_PIX, TX_HW, TX_HH, TX_RD, TX_PIX, ERR.
REQ-006 IDLE: start=1 -> HDR_W, clear err, latch mode; start while busy SHALL be ignored.
REQ-007 HDR_W/HDR_H: when rx_empty=0, pulse rd_uart one cycle and latch r_data as W resp. H; advance next cycle.
REQ-008 rd_uart SHALL never assert while rx_empty=1; at most one pop per cycle.
REQ-009 CHECK: N = W*H as 16-bit unsigned; N=0 or N>MAX_PIX -> ERR; else RX_PIX with pixel counter=0.
REQ-010 RX_PIX: per available byte, pulse rd_uart, mem_we=1, mem_addr=counter, mem_wdata=r_data in the same cycle; counter+1; after byte N-1 -> TX_HW.
REQ-011 Receive timeout: counter of cycles with rx_empty=1 in HDR_W, HDR_H, RX_PIX; reaching TIMEOUT -> ERR; counter clears on every pop.
REQ-012 TX_HW/TX_HH: when tx_full=0, wr_uart pulse with w_data=W resp. H (header echo).
REQ-013 TX_RD: drive mem_addr=counter (counter reset to 0 entering first TX_RD); next cycle TX_PIX.
REQ-014 TX_PIX: hold mem_rdata result in a register on entry; when tx_full=0, wr_uart with w_data=op(pixel); last pixel -> IDLE with done pulse; else counter+1 -> TX_RD.
REQ-015 wr_uart SHALL never assert while tx_full=1; w_data stable while wr_uart=1.
REQ-016 op: pass p; invert 255-p; threshold p>=128 ? 255 : 0; +1 saturates at 255 (255 -> 255).
REQ-017 ERR: err=1, no UART or memory strobes; next cycle -> IDLE with err held until next accepted start.
REQ-018 Outputs rd_uart, wr_uart, mem_we, done SHALL be 0 in every state not listed as driving them.

Reset
REQ-019 reset=0 SHALL asynchronously force IDLE, counters=0, W=H=0, and all outputs 0 (mem_addr=0, w_data=0, err=0, busy=0).
REQ-020 reset mid-frame SHALL abort without further strobes; UART FIFO contents not drained.

Structure
REQ-021 State encoding, mode codes and header length constant SHALL live in shared package img_pkg.
REQ-022 Pixel op SHALL be a combinational sub-module pix_op (8-bit in, mode, 8-bit out).

Verification
REQ-023 W=2,H=2, pixels 0x10,0x80,0xFF,0x00, mode=1 -> TX 0x02,0x02,0xEF,0x7F,0x00,0xFF; one done pulse.
REQ-024 Same frame, mode=2 then mode=3 -> 0x00,0xFF,0xFF,0x00 and 0x11,0x81,0xFF,0x01.
REQ-025 W=0 or W=65,H=64 (N=4160>4096) -> err=1, no mem_we, no wr_uart, busy drops after ERR.
REQ-026 tx_full held 1 for 20 cycles mid-transmit -> no wr_uart during stall, byte order unchanged afterward.
REQ-027 Only 3 of 4 pixels sent, TIMEOUT=100 -> err=1 at 100 idle cycles; new start then valid frame -> err cleared, done pulse.
REQ-028 reset asserted during RX_PIX -> all outputs 0 same cycle; start after release processes a full frame correctly.
